mul_seq_cla: RTL and testbench

//  Multi-cycle unsigned 32x32->64 shift-add multiplier.

---
 rtl/mul_seq_pkg.sv | 14 +
 rtl/cla.sv | 40 ++++
 rtl/mul_seq_cla.sv | 106 ++++++++++
 tb/tb_mul_seq_cla.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and sizing for the sequential multiplier
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 5;
    localparam int MUL_ITERS = 32;

endpackage

// File: rtl/cla.sv
// rtl/cla.sv - 32-bit carry-lookahead adder, 4-bit lookahead groups
module cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic        grp_c;
    logic        grp_g;
    logic        grp_p;

    assign g = a & b;
    assign p = a ^ b;

    // Carries inside a group are fully expanded; group carries chain between groups.
    always_comb begin
        c     = '0;
        grp_c = cin;
        grp_g = 1'b0;
        grp_p = 1'b0;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = grp_c;
            c[4*k+1] = g[4*k] | (p[4*k] & grp_c);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c);
            grp_g    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p    = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            grp_c    = grp_g | (grp_p & grp_c);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/mul_seq_cla.sv
// rtl/mul_seq_cla.sv - sequential 32x32->64 shift-add multiplier with valid/ready
module mul_seq_cla
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);

    if (WIDTH != MUL_WIDTH) begin : g_width_check
        $error("mul_seq_cla: WIDTH must be 32");
    end

    mul_state_t             state;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       hi;
    logic [WIDTH-1:0]       lo;
    logic [WIDTH-1:0]       addend;
    logic [WIDTH-1:0]       sum;
    logic                   carry;
    logic [WIDTH-1:0]       step_hi;
    logic [WIDTH-1:0]       step_lo;
    logic [MUL_CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]       tag_q;
    logic [TAG_W-1:0]       out_tag_q;
    logic [2*WIDTH-1:0]     prod_q;

    assign addend = lo[0] ? mcand : '0;

    cla u_cla (
        .a   (hi),
        .b   (addend),
        .cin (1'b0),
        .sum (sum)
    );

    // The adder has no carry-out port; recover it from the operand and sum MSBs.
    assign carry   = (hi[WIDTH-1] & addend[WIDTH-1])
                   | ((hi[WIDTH-1] | addend[WIDTH-1]) & ~sum[WIDTH-1]);
    assign step_hi = {carry, sum[WIDTH-1:1]};
    assign step_lo = {sum[0], lo[WIDTH-1:1]};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_prod  = prod_q;
    assign out_tag   = out_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            tag_q     <= '0;
            prod_q    <= '0;
            out_tag_q <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= in_a;
                        hi    <= '0;
                        lo    <= in_b;
                        tag_q <= in_tag;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt + 1'b1;
                    // Result registers only move here so they hold outside DONE.
                    if (cnt == MUL_CNT_W'(MUL_ITERS - 1)) begin
                        prod_q    <= {step_hi, step_lo};
                        out_tag_q <= tag_q;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_cla.sv
// tb/tb_mul_seq_cla.sv - directed and randomized checks for mul_seq_cla
module tb_mul_seq_cla;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prod;
    logic [3:0]  out_tag;

    int errors = 0;
    int checks = 0;

    mul_seq_cla #(.WIDTH(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        check("latency", 64'(lat), 64'd32);
    endtask

    task automatic drain(input logic [63:0] exp_prod, input logic [3:0] exp_tag, input int stall);
        check("prod", out_prod, exp_prod);
        check("tag", 64'(out_tag), 64'(exp_tag));
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_after_drain", 64'(out_valid), 64'd0);
        check("ready_after_drain", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                          input logic [63:0] exp_prod, input int stall);
        start_op(a, b, t);
        wait_result();
        drain(exp_prod, t, stall);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rt;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_prod", out_prod, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);

        run_op(32'd3, 32'd5, 4'd2, 64'd15, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 64'hFFFF_FFFE_0000_0001, 0);
        run_op(32'd0, 32'h8000_0000, 4'd3, 64'd0, 0);
        run_op(32'h8000_0000, 32'd2, 4'd4, 64'h1_0000_0000, 0);
        run_op(32'd1234, 32'd1000, 4'hF, 64'd1234000, 2);

        // Output stall with a competing request held on the input
        start_op(32'd100, 32'd200, 4'd9);
        wait_result();
        in_a     = 32'd11;
        in_b     = 32'd13;
        in_tag   = 4'd6;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_prod", out_prod, 64'd20000);
            check("stall_tag", 64'(out_tag), 64'd9);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("no_accept_on_drain", 64'(in_ready), 64'd1);
        check("stall_drained", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("held_req_accepted", 64'(in_ready), 64'd0);
        wait_result();
        check("held_req_lat_prod", out_prod, 64'd143);
        drain(64'd143, 4'd6, 0);

        // Flush mid-computation, with an in_valid on the flush edge
        start_op(32'hDEAD_BEEF, 32'h1234_5678, 4'd7);
        repeat (9) @(negedge clk);
        flush    = 1'b1;
        in_a     = 32'd1;
        in_b     = 32'd1;
        in_tag   = 4'd8;
        in_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("flush_no_accept", 64'(in_ready), 64'd1);
        run_op(32'd7, 32'd6, 4'd10, 64'd42, 0);

        // Reset while a result is waiting
        start_op(32'd9, 32'd9, 4'd3);
        wait_result();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_done_out_valid", 64'(out_valid), 64'd0);
        check("rst_done_in_ready", 64'(in_ready), 64'd1);
        check("rst_done_prod", out_prod, 64'd0);
        check("rst_done_tag", 64'(out_tag), 64'd0);
        run_op(32'd7, 32'd6, 4'd5, 64'd42, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rt = 4'(i);
            run_op(ra, rb, rt, {32'd0, ra} * {32'd0, rb}, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
